// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory arbiter: address/data widths
// and the owner encoding that tags the read in flight.
package dmem_pkg;

  localparam int AW_DEF = 12;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_P0   = 2'b01,
    OWN_P1   = 2'b10
  } owner_e;

  // An all-zero byte-enable vector means the access is a read.
  function automatic logic is_read(input logic [3:0] we);
    return (we == 4'h0);
  endfunction

endpackage : dmem_pkg

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports and the memory port of dmem_arbiter.
// slave = the arbiter's view; master = the requesters and memory around it.
interface dmem_arbiter_if #(
  parameter int AW = 12,
  parameter int DW = 32
);

  logic          p0_req;
  logic [3:0]    p0_we;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata;
  logic          p0_gnt;
  logic          p0_rvalid;
  logic [DW-1:0] p0_rdata;

  logic          p1_req;
  logic [3:0]    p1_we;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata;
  logic          p1_gnt;
  logic          p1_rvalid;
  logic [DW-1:0] p1_rdata;

  logic          mem_cen;
  logic          mem_rd_en;
  logic [3:0]    mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_gnt, p0_rvalid, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output mem_cen, mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_gnt, p0_rvalid, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  mem_cen, mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface : dmem_arbiter_if

// File: rtl/dmem_arb_starve_ctr.sv
// Port-1 starvation counter: counts consecutive denied port-1 cycles and forces
// a port-1 grant at STARVE_LIMIT. Compiled only when DMEM_ARB_STARVE_EN is defined.
`ifdef DMEM_ARB_STARVE_EN
module dmem_arb_starve_ctr #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic clock,
  input  logic reset_n,
  input  logic p1_req_i,
  input  logic p1_gnt_i,
  output logic force_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!p1_req_i || p1_gnt_i) begin
      cnt_d = 8'd0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Forcing the grant at the limit clears the count, so it never passes 255.
  assign force_o = (cnt_q == 8'(STARVE_LIMIT));

endmodule : dmem_arb_starve_ctr
`endif

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: port 0 has fixed priority,
// read data returns to the winner one cycle later. DMEM_ARB_STARVE_EN adds the port-1 guard.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF,
  parameter int STARVE_LIMIT = 8
) (
  input  logic           clock,
  input  logic           reset_n,
  dmem_arbiter_if.slave  bus
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
    $error("dmem_arbiter: STARVE_LIMIT must be in 1..255");
  end

  logic          p0_gnt, p1_gnt, p1_force;
  logic          cen, rd_en;
  logic [3:0]    wr_en;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  owner_e        owner_q, owner_d;
  logic [DW-1:0] p0_hold_q, p1_hold_q;

`ifdef DMEM_ARB_STARVE_EN
  dmem_arb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clock    (clock),
    .reset_n  (reset_n),
    .p1_req_i (bus.p1_req),
    .p1_gnt_i (p1_gnt),
    .force_o  (p1_force)
  );
`else
  assign p1_force = 1'b0;
`endif

  // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    p0_gnt  = 1'b0;
    p1_gnt  = 1'b0;
    cen     = 1'b0;
    rd_en   = 1'b0;
    wr_en   = 4'h0;
    addr    = '0;
    wdata   = '0;
    owner_d = OWN_NONE;

    if (p1_force && bus.p1_req) begin
      p1_gnt = 1'b1;
    end else if (bus.p0_req) begin
      p0_gnt = 1'b1;
    end else if (bus.p1_req) begin
      p1_gnt = 1'b1;
    end

    if (p0_gnt) begin
      cen     = 1'b1;
      rd_en   = is_read(bus.p0_we);
      wr_en   = bus.p0_we;
      addr    = bus.p0_addr;
      wdata   = bus.p0_wdata;
      owner_d = is_read(bus.p0_we) ? OWN_P0 : OWN_NONE;
    end else if (p1_gnt) begin
      cen     = 1'b1;
      rd_en   = is_read(bus.p1_we);
      wr_en   = bus.p1_we;
      addr    = bus.p1_addr;
      wdata   = bus.p1_wdata;
      owner_d = is_read(bus.p1_we) ? OWN_P1 : OWN_NONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      owner_q   <= OWN_NONE;
      // NOTE: the hold registers are ordinary flops, not a memory array, so they are reset and rdata reads 0 out of reset.
      p0_hold_q <= '0;
      p1_hold_q <= '0;
    end else begin
      owner_q <= owner_d;
      if (owner_q == OWN_P0) p0_hold_q <= bus.mem_rdata;
      if (owner_q == OWN_P1) p1_hold_q <= bus.mem_rdata;
    end
  end

  assign bus.p0_gnt    = p0_gnt;
  assign bus.p1_gnt    = p1_gnt;
  assign bus.mem_cen   = cen;
  assign bus.mem_rd_en = rd_en;
  assign bus.mem_wr_en = wr_en;
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = wdata;

  // The returning word is shown in its valid cycle and held afterwards until the port's next read.
  assign bus.p0_rvalid = (owner_q == OWN_P0);
  assign bus.p1_rvalid = (owner_q == OWN_P1);
  assign bus.p0_rdata  = (owner_q == OWN_P0) ? bus.mem_rdata : p0_hold_q;
  assign bus.p1_rdata  = (owner_q == OWN_P1) ? bus.mem_rdata : p1_hold_q;

endmodule : dmem_arbiter

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a vector table for single-cycle behaviour plus
// hand sequences for priority/starvation and reset during a read.
module tb_dmem_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int LIMIT = 4;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  dmem_arbiter #(
    .AW           (AW),
    .DW           (DW),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Synchronous single-port memory: byte writes, read data valid the cycle after issue.
  logic [DW-1:0] mem [1 << AW];
  always @(posedge clock) begin
    if (!reset_n) begin
      // NOTE: only the words the test reads are preloaded; the rest of the array is never cleared.
      mem[12'h010]  <= 32'hDEADBEEF;
      mem[12'h001]  <= 32'hA1A1A1A1;
      mem[12'h002]  <= 32'hB2B2B2B2;
      bus.mem_rdata <= '0;
    end else if (bus.mem_cen) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.mem_wr_en[b]) mem[bus.mem_addr][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
      end
      if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  typedef struct {
    logic          p0_req;
    logic [3:0]    p0_we;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata;
    logic          p1_req;
    logic [3:0]    p1_we;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata;
    logic          e_p0_gnt;
    logic          e_p1_gnt;
    logic          e_p0_rv;
    logic [DW-1:0] e_p0_rd;
    logic          e_p1_rv;
    logic [DW-1:0] e_p1_rd;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic [3:0] we0, input logic [AW-1:0] a0,
                       input logic [DW-1:0] d0, input logic r1, input logic [3:0] we1,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    bus.p0_req = r0; bus.p0_we = we0; bus.p0_addr = a0; bus.p0_wdata = d0;
    bus.p1_req = r1; bus.p1_we = we1; bus.p1_addr = a1; bus.p1_wdata = d1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " p0_gnt"},    32'(bus.p0_gnt),    32'd0);
    check({tag, " p1_gnt"},    32'(bus.p1_gnt),    32'd0);
    check({tag, " p0_rvalid"}, 32'(bus.p0_rvalid), 32'd0);
    check({tag, " p1_rvalid"}, 32'(bus.p1_rvalid), 32'd0);
    check({tag, " p0_rdata"},  bus.p0_rdata,       32'd0);
    check({tag, " p1_rdata"},  bus.p1_rdata,       32'd0);
    check({tag, " mem_cen"},   32'(bus.mem_cen),   32'd0);
    check({tag, " mem_rd_en"}, 32'(bus.mem_rd_en), 32'd0);
    check({tag, " mem_wr_en"}, 32'(bus.mem_wr_en), 32'd0);
    check({tag, " mem_addr"},  32'(bus.mem_addr),  32'd0);
    check({tag, " mem_wdata"}, bus.mem_wdata,      32'd0);
  endtask

  initial begin
    logic          e_cen, e_rd;
    logic [3:0]    e_wr;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic          e_p1;
    string         tag;

    //          p0 req/we/addr/wdata            p1 req/we/addr/wdata              gnt0 gnt1 rv0 rd0            rv1 rd1
    vecs[0]  = '{1'b1, 4'h0, 12'h010, 32'h0,        1'b0, 4'h0, 12'h000, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[1]  = '{1'b1, 4'hF, 12'h020, 32'h12345678, 1'b0, 4'h0, 12'h000, 32'h0,        1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 4'h0, 12'h000, 32'h0,        1'b1, 4'h0, 12'h020, 32'h0,        1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 4'h0, 12'h000, 32'h0,        1'b0, 4'h0, 12'h000, 32'h0,        1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1, 32'h12345678};
    vecs[4]  = '{1'b1, 4'h0, 12'h001, 32'h0,        1'b1, 4'h0, 12'h002, 32'h0,        1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h12345678};
    vecs[5]  = '{1'b1, 4'h0, 12'h001, 32'h0,        1'b1, 4'h0, 12'h002, 32'h0,        1'b1, 1'b0, 1'b1, 32'hA1A1A1A1, 1'b0, 32'h12345678};
    vecs[6]  = '{1'b1, 4'h0, 12'h001, 32'h0,        1'b1, 4'h0, 12'h002, 32'h0,        1'b1, 1'b0, 1'b1, 32'hA1A1A1A1, 1'b0, 32'h12345678};
    vecs[7]  = '{1'b0, 4'h0, 12'h000, 32'h0,        1'b1, 4'h0, 12'h002, 32'h0,        1'b0, 1'b1, 1'b1, 32'hA1A1A1A1, 1'b0, 32'h12345678};
    vecs[8]  = '{1'b1, 4'h0, 12'h001, 32'h0,        1'b0, 4'h0, 12'h000, 32'h0,        1'b1, 1'b0, 1'b0, 32'hA1A1A1A1, 1'b1, 32'hB2B2B2B2};
    vecs[9]  = '{1'b0, 4'h0, 12'h000, 32'h0,        1'b1, 4'h0, 12'h002, 32'h0,        1'b0, 1'b1, 1'b1, 32'hA1A1A1A1, 1'b0, 32'hB2B2B2B2};
    vecs[10] = '{1'b1, 4'h0, 12'h001, 32'h0,        1'b0, 4'h0, 12'h000, 32'h0,        1'b1, 1'b0, 1'b0, 32'hA1A1A1A1, 1'b1, 32'hB2B2B2B2};
    vecs[11] = '{1'b0, 4'h0, 12'h000, 32'h0,        1'b0, 4'h0, 12'h000, 32'h0,        1'b0, 1'b0, 1'b1, 32'hA1A1A1A1, 1'b0, 32'hB2B2B2B2};
    vecs[12] = '{1'b0, 4'h0, 12'h000, 32'h0,        1'b1, 4'h3, 12'h020, 32'hAAAA5555, 1'b0, 1'b1, 1'b0, 32'hA1A1A1A1, 1'b0, 32'hB2B2B2B2};
    vecs[13] = '{1'b1, 4'h0, 12'h020, 32'h0,        1'b0, 4'h0, 12'h000, 32'h0,        1'b1, 1'b0, 1'b0, 32'hA1A1A1A1, 1'b0, 32'hB2B2B2B2};
    vecs[14] = '{1'b0, 4'h0, 12'h000, 32'h0,        1'b0, 4'h0, 12'h000, 32'h0,        1'b0, 1'b0, 1'b1, 32'h12345555, 1'b0, 32'hB2B2B2B2};

    drive(1'b0, 4'h0, '0, '0, 1'b0, 4'h0, '0, '0);
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_all_zero("reset");
    @(posedge clock); #1;
    reset_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      @(posedge clock); #1;
      drive(vecs[i].p0_req, vecs[i].p0_we, vecs[i].p0_addr, vecs[i].p0_wdata,
            vecs[i].p1_req, vecs[i].p1_we, vecs[i].p1_addr, vecs[i].p1_wdata);
      e_cen = 1'b0; e_rd = 1'b0; e_wr = 4'h0; e_addr = '0; e_wdata = '0;
      if (vecs[i].e_p0_gnt) begin
        e_cen = 1'b1; e_rd = (vecs[i].p0_we == 4'h0); e_wr = vecs[i].p0_we;
        e_addr = vecs[i].p0_addr; e_wdata = vecs[i].p0_wdata;
      end else if (vecs[i].e_p1_gnt) begin
        e_cen = 1'b1; e_rd = (vecs[i].p1_we == 4'h0); e_wr = vecs[i].p1_we;
        e_addr = vecs[i].p1_addr; e_wdata = vecs[i].p1_wdata;
      end
      @(negedge clock);
      tag = $sformatf("v%0d", i);
      check({tag, " p0_gnt"},    32'(bus.p0_gnt),    32'(vecs[i].e_p0_gnt));
      check({tag, " p1_gnt"},    32'(bus.p1_gnt),    32'(vecs[i].e_p1_gnt));
      check({tag, " p0_rvalid"}, 32'(bus.p0_rvalid), 32'(vecs[i].e_p0_rv));
      check({tag, " p0_rdata"},  bus.p0_rdata,       vecs[i].e_p0_rd);
      check({tag, " p1_rvalid"}, 32'(bus.p1_rvalid), 32'(vecs[i].e_p1_rv));
      check({tag, " p1_rdata"},  bus.p1_rdata,       vecs[i].e_p1_rd);
      check({tag, " mem_cen"},   32'(bus.mem_cen),   32'(e_cen));
      check({tag, " mem_rd_en"}, 32'(bus.mem_rd_en), 32'(e_rd));
      check({tag, " mem_wr_en"}, 32'(bus.mem_wr_en), 32'(e_wr));
      check({tag, " mem_addr"},  32'(bus.mem_addr),  32'(e_addr));
      check({tag, " mem_wdata"}, bus.mem_wdata,      e_wdata);
    end

    // Both ports requesting continuously: guard build lets p1 through every LIMIT+1 cycles.
    for (int c = 1; c <= 15; c++) begin
      @(posedge clock); #1;
      drive(1'b1, 4'h0, 12'h001, '0, 1'b1, 4'h0, 12'h002, '0);
      @(negedge clock);
`ifdef DMEM_ARB_STARVE_EN
      e_p1 = ((c % (LIMIT + 1)) == 0);
`else
      e_p1 = 1'b0;
`endif
      tag = $sformatf("starve c%0d", c);
      check({tag, " p1_gnt"}, 32'(bus.p1_gnt), 32'(e_p1));
      check({tag, " p0_gnt"}, 32'(bus.p0_gnt), 32'(!e_p1));
    end
    @(posedge clock); #1;
    drive(1'b0, 4'h0, '0, '0, 1'b0, 4'h0, '0, '0);

    // Reset asserted the cycle after a p1 read grant drops the in-flight rvalid.
    @(posedge clock); #1;
    drive(1'b0, 4'h0, '0, '0, 1'b1, 4'h0, 12'h002, '0);
    @(negedge clock);
    check("rst_mid grant p1_gnt", 32'(bus.p1_gnt), 32'd1);
    @(posedge clock); #1;
    drive(1'b0, 4'h0, '0, '0, 1'b0, 4'h0, '0, '0);
    reset_n = 1'b0;
    @(negedge clock);
    check_all_zero("rst_mid");
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    drive(1'b1, 4'h0, 12'h010, '0, 1'b0, 4'h0, '0, '0);
    @(negedge clock);
    check("post_rst p0_gnt", 32'(bus.p0_gnt), 32'd1);
    @(posedge clock); #1;
    drive(1'b0, 4'h0, '0, '0, 1'b0, 4'h0, '0, '0);
    @(negedge clock);
    check("post_rst p0_rvalid", 32'(bus.p0_rvalid), 32'd1);
    check("post_rst p0_rdata",  bus.p0_rdata,       32'hDEADBEEF);
    check("post_rst p1_rvalid", 32'(bus.p1_rvalid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_dmem_arbiter
